// File: rtl/cache_ctrl_nway_if.sv
// CPU load/store port and line-granular memory port of the N-way cache.
// Handshakes: the CPU raises cpu_valid_i and holds it with stable fields until
// the one-cycle cpu_ready_o pulse; the controller raises mem_valid_o with stable
// mem_rw_o/mem_addr_o/mem_wdata_o until a cycle with mem_ready_i high, and
// drops mem_valid_o in the following cycle. Read fill data is valid on
// mem_rdata_i in the mem_ready_i cycle.
interface cache_ctrl_nway_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4
);
  logic                     cpu_valid_i;
  logic [ADDR_W-1:0]        cpu_addr_i;
  logic                     cpu_rw_i;
  logic [31:0]              cpu_wdata_i;
  logic [3:0]               cpu_wstrb_i;
  logic                     cpu_ready_o;
  logic [31:0]              cpu_rdata_o;
  logic                     mem_valid_o;
  logic                     mem_rw_o;
  logic [ADDR_W-1:0]        mem_addr_o;
  logic [LINE_WORDS*32-1:0] mem_wdata_o;
  logic                     mem_ready_i;
  logic [LINE_WORDS*32-1:0] mem_rdata_i;

  // Environment side: drives CPU requests and answers memory requests.
  modport master (
    output cpu_valid_i, cpu_addr_i, cpu_rw_i, cpu_wdata_i, cpu_wstrb_i,
    output mem_ready_i, mem_rdata_i,
    input  cpu_ready_o, cpu_rdata_o, mem_valid_o, mem_rw_o, mem_addr_o, mem_wdata_o
  );

  // Cache controller side.
  modport slave (
    input  cpu_valid_i, cpu_addr_i, cpu_rw_i, cpu_wdata_i, cpu_wstrb_i,
    input  mem_ready_i, mem_rdata_i,
    output cpu_ready_o, cpu_rdata_o, mem_valid_o, mem_rw_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/cache_ctrl_nway.sv
// N-way set-associative write-back, write-allocate cache controller with
// byte-strobed writes and tree pseudo-LRU replacement. All storage in flops.
module cache_ctrl_nway #(
  parameter int WAYS       = 8,
  parameter int SETS       = 4,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  cache_ctrl_nway_if.slave    bus,
  output logic [1:0]          dbg_state
);
  localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int LW     = LINE_WORDS * 32;
  localparam int WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] COMPARE   = 2'd1;
  localparam logic [1:0] WRITEBACK = 2'd2;
  localparam logic [1:0] ALLOCATE  = 2'd3;

  logic [1:0]        state_q;
  logic [ADDR_W-1:0] req_addr;
  logic              req_rw;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic [WAY_W-1:0]  victim_q;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAYS-2:0]   plru_q  [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LW-1:0]     line_q  [SETS][WAYS];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] req_word;

  assign req_idx   = req_addr[OFF_W +: IDX_W];
  assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
  assign dbg_state = state_q;

  if (LINE_WORDS > 1) begin : g_wsel
    assign req_word = req_addr[OFF_W-1:2];
  end else begin : g_wsel_single
    assign req_word = '0;
  end

  // Tree PLRU access: every node on the way's path points at the other half.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] old,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0] t;
    logic [WAY_W:0]  n;
    logic            d;
    t = old;
    n = '0;
    for (int l = 0; l < WAY_W; l++) begin
      d = way[WAY_W-1-l];
      t[n[WAY_W-1:0]] = ~d;
      n = {n[WAY_W-1:0], 1'b0} + (WAY_W+1)'(1) + {{WAY_W{1'b0}}, d};
    end
    return t;
  endfunction

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             has_inv;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] plru_way;
  logic [WAY_W-1:0] victim;
  logic [WAY_W:0]   node;
  logic             node_bit;
  logic [LW-1:0]    cur_line;
  logic [31:0]      cur_word;
  logic [31:0]      merged;
  logic [LW-1:0]    new_line;

  // Tag compare across all ways of the requested set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim choice: lowest-index invalid way, else walk the PLRU tree.
  always_comb begin
    has_inv  = 1'b0;
    inv_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    node     = '0;
    node_bit = 1'b0;
    plru_way = '0;
    for (int l = 0; l < WAY_W; l++) begin
      node_bit = plru_q[req_idx][node[WAY_W-1:0]];
      plru_way = (plru_way << 1) | WAY_W'(node_bit);
      node     = {node[WAY_W-1:0], 1'b0} + (WAY_W+1)'(1) + {{WAY_W{1'b0}}, node_bit};
    end
    victim = has_inv ? inv_way : plru_way;
  end

  // Word select and byte-strobed merge for the hit line.
  always_comb begin
    cur_line = line_q[req_idx][hit_way];
    cur_word = cur_line[int'(req_word)*32 +: 32];
    merged   = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (req_wstrb[b]) merged[b*8 +: 8] = req_wdata[b*8 +: 8];
    end
    new_line = cur_line;
    new_line[int'(req_word)*32 +: 32] = merged;
  end

  // Controller FSM, cache storage and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      req_addr        <= '0;
      req_rw          <= 1'b0;
      req_wdata       <= '0;
      req_wstrb       <= '0;
      victim_q        <= '0;
      bus.cpu_ready_o <= 1'b0;
      bus.cpu_rdata_o <= '0;
      bus.mem_valid_o <= 1'b0;
      bus.mem_rw_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      bus.cpu_ready_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cpu_valid_i) begin
            req_addr  <= bus.cpu_addr_i;
            req_rw    <= bus.cpu_rw_i;
            req_wdata <= bus.cpu_wdata_i;
            req_wstrb <= bus.cpu_wstrb_i;
            state_q   <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (req_rw) begin
              line_q[req_idx][hit_way]  <= new_line;
              dirty_q[req_idx][hit_way] <= 1'b1;
            end else begin
              bus.cpu_rdata_o <= cur_word;
            end
            plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
            bus.cpu_ready_o <= 1'b1;
            state_q         <= IDLE;
          end else begin
            victim_q        <= victim;
            bus.mem_valid_o <= 1'b1;
            if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
              bus.mem_rw_o    <= 1'b1;
              bus.mem_addr_o  <= {tag_q[req_idx][victim], req_idx, {OFF_W{1'b0}}};
              bus.mem_wdata_o <= line_q[req_idx][victim];
              state_q         <= WRITEBACK;
            end else begin
              bus.mem_rw_o    <= 1'b0;
              bus.mem_addr_o  <= {req_tag, req_idx, {OFF_W{1'b0}}};
              state_q         <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          // Drop valid for a cycle so the fill is a fresh request.
          if (bus.mem_ready_i) begin
            bus.mem_valid_o <= 1'b0;
            state_q         <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (!bus.mem_valid_o) begin
            bus.mem_valid_o <= 1'b1;
            bus.mem_rw_o    <= 1'b0;
            bus.mem_addr_o  <= {req_tag, req_idx, {OFF_W{1'b0}}};
          end else if (bus.mem_ready_i) begin
            line_q[req_idx][victim_q]  <= bus.mem_rdata_i;
            tag_q[req_idx][victim_q]   <= req_tag;
            valid_q[req_idx][victim_q] <= 1'b1;
            dirty_q[req_idx][victim_q] <= 1'b0;
            plru_q[req_idx]            <= plru_touch(plru_q[req_idx], victim_q);
            bus.mem_valid_o            <= 1'b0;
            state_q                    <= COMPARE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Bench for cache_ctrl_nway: directed scenarios then random traffic, checked
// against a flat-memory view plus a set/way occupancy model with timestamps.
module tb_cache_ctrl_nway;
  localparam int WAYS = 8, SETS = 4, LINE_WORDS = 4, ADDR_W = 32;
  localparam int LB = LINE_WORDS * 4;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;
  int n_tests = 0;
  int n_fail = 0;

  cache_ctrl_nway_if #(.ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS)) bus ();
  cache_ctrl_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W))
    dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus), .dbg_state(dbg_state));

  // clock
  always #5 clk = ~clk;

  // scoreboard: expected memory transactions {rw, addr} in order
  logic [ADDR_W:0] exp_q[$];
  logic [LINE_WORDS*32-1:0] exp_wb_line;
  logic [31:0] flat [logic [31:0]];
  logic [31:0] back_mem [logic [31:0]];

  // occupancy model
  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  int unsigned m_use   [SETS][WAYS];
  int unsigned tick;

  // observations of the last access
  logic [31:0] last_rd;
  int          last_cycles;
  int          last_txn;
  int          last_high;
  bit          wb0_seen;
  logic [31:0] wb0_word;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] get_flat(input logic [31:0] a);
    if (flat.exists(a)) return flat[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] get_back(input logic [31:0] a);
    if (back_mem.exists(a)) return back_mem[a];
    return dflt(a);
  endfunction

  // Tree-PLRU victim: in every subtree, avoid the half holding the most
  // recently used way; an untouched subtree sends the victim low.
  function automatic int pick_victim(input int s);
    int lo, n, half, bw;
    int unsigned best;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    lo = 0;
    n = WAYS;
    while (n > 1) begin
      half = n / 2;
      best = 0;
      bw = -1;
      for (int i = lo; i < lo + n; i++) begin
        if (m_use[s][i] > best) begin best = m_use[s][i]; bw = i; end
      end
      if (bw >= 0 && bw < lo + half) lo = lo + half;
      n = half;
    end
    return lo;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = 0; m_use[s][w] = 0;
      end
    tick = 0;
    flat.delete();
    foreach (back_mem[k]) flat[k] = back_mem[k];
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // driver: one CPU request, acting as the memory while it is in flight
  task automatic access(input logic [31:0] a, input logic rw, input logic [31:0] wd,
                        input logic [3:0] ws, input int dly, input bit toggle);
    int s, hw, v, cycles, wait_cnt;
    int unsigned t;
    bit exp_hit, done;
    logic [31:0] exp_rd, wa, fa, first_addr, nw;
    logic first_rw;
    logic [LINE_WORDS*32-1:0] first_wdata, fill;
    logic [ADDR_W:0] obs, exp;

    s = int'((a / LB) % SETS);
    t = a / (LB * SETS);
    hw = -1;
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    exp_hit = (hw >= 0);
    if (!exp_hit) begin
      v = pick_victim(s);
      if (m_valid[s][v] && m_dirty[s][v]) begin
        wa = (m_tag[s][v] * SETS + s) * LB;
        exp_q.push_back({1'b1, wa});
        for (int k = 0; k < LINE_WORDS; k++) exp_wb_line[k*32 +: 32] = get_flat(wa + 4*k);
      end
      fa = (t * SETS + s) * LB;
      exp_q.push_back({1'b0, fa});
      m_valid[s][v] = 1; m_dirty[s][v] = 0; m_tag[s][v] = t;
      hw = v;
    end
    tick++;
    m_use[s][hw] = tick;
    exp_rd = get_flat(a);
    if (rw) begin
      m_dirty[s][hw] = 1;
      nw = exp_rd;
      for (int b = 0; b < 4; b++) if (ws[b]) nw[b*8 +: 8] = wd[b*8 +: 8];
      flat[a] = nw;
    end

    @(negedge clk);
    bus.cpu_valid_i = 1'b1; bus.cpu_addr_i = a; bus.cpu_rw_i = rw;
    bus.cpu_wdata_i = wd; bus.cpu_wstrb_i = ws;
    cycles = 0; done = 0; wait_cnt = 0; last_txn = 0;
    first_addr = '0; first_rw = 1'b0; first_wdata = '0;
    while (!done && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (bus.mem_ready_i) begin
        bus.mem_ready_i = 1'b0;
        wait_cnt = 0;
      end else if (bus.mem_valid_o) begin
        if (wait_cnt == 0) begin
          first_addr = bus.mem_addr_o; first_rw = bus.mem_rw_o; first_wdata = bus.mem_wdata_o;
        end else begin
          n_tests++;
          assert ({bus.mem_rw_o, bus.mem_addr_o} === {first_rw, first_addr}) else begin
            n_fail++;
            $error("FAIL mem_hold obs=%0h exp=%0h", {bus.mem_rw_o, bus.mem_addr_o}, {first_rw, first_addr});
          end
          if (first_rw) begin
            n_tests++;
            assert (bus.mem_wdata_o === first_wdata) else begin
              n_fail++; $error("FAIL wdata_hold obs=%0h exp=%0h", bus.mem_wdata_o, first_wdata);
            end
          end
        end
        if (wait_cnt == dly) begin
          bus.mem_ready_i = 1'b1;
          last_txn++;
          last_high = wait_cnt + 1;
          obs = {bus.mem_rw_o, bus.mem_addr_o};
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          n_tests++;
          assert (obs === exp) else begin
            n_fail++; $error("FAIL mem_txn obs=%0h exp=%0h", obs, exp);
          end
          if (bus.mem_rw_o) begin
            n_tests++;
            assert (bus.mem_wdata_o === exp_wb_line) else begin
              n_fail++; $error("FAIL wb_line obs=%0h exp=%0h", bus.mem_wdata_o, exp_wb_line);
            end
            for (int k = 0; k < LINE_WORDS; k++)
              back_mem[bus.mem_addr_o + 4*k] = bus.mem_wdata_o[k*32 +: 32];
            if (bus.mem_addr_o == 32'h0) begin wb0_seen = 1; wb0_word = bus.mem_wdata_o[31:0]; end
          end else begin
            for (int k = 0; k < LINE_WORDS; k++) fill[k*32 +: 32] = get_back(bus.mem_addr_o + 4*k);
            bus.mem_rdata_i = fill;
          end
        end
        wait_cnt++;
      end
      if (bus.cpu_ready_o) begin
        done = 1;
        last_rd = bus.cpu_rdata_o;
      end else if (toggle && cycles > 1) begin
        bus.cpu_valid_i = 1'($urandom_range(1, 0));
        bus.cpu_addr_i = $urandom & 32'hFFFF_FFFC;
        bus.cpu_rw_i = 1'($urandom_range(1, 0));
      end
    end
    bus.cpu_valid_i = 1'b0;
    last_cycles = cycles;

    n_tests++;
    assert (done === 1'b1) else begin n_fail++; $error("FAIL ready_timeout obs=%0d exp=1", done); end
    n_tests++;
    assert (exp_q.size() === 0) else begin
      n_fail++; $error("FAIL missing_txn obs=%0d exp=0", exp_q.size());
    end
    exp_q.delete();
    if (exp_hit) begin
      n_tests++;
      assert (cycles === 2) else begin n_fail++; $error("FAIL hit_latency obs=%0d exp=2", cycles); end
    end
    if (!rw) begin
      n_tests++;
      assert (last_rd === exp_rd) else begin
        n_fail++; $error("FAIL rdata addr=%0h obs=%0h exp=%0h", a, last_rd, exp_rd);
      end
    end
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin n_fail++; $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp); end
  endtask

  initial begin
    bus.cpu_valid_i = 0; bus.cpu_addr_i = '0; bus.cpu_rw_i = 0;
    bus.cpu_wdata_i = '0; bus.cpu_wstrb_i = '0;
    bus.mem_ready_i = 0; bus.mem_rdata_i = '0;
    wb0_seen = 0; wb0_word = '0; last_high = 0;
    back_mem[32'h40] = 32'h11; back_mem[32'h44] = 32'h22;
    back_mem[32'h48] = 32'h33; back_mem[32'h4C] = 32'h44;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // reset values
    check("rst_ready", 128'(bus.cpu_ready_o), 128'(0));
    check("rst_rdata", 128'(bus.cpu_rdata_o), 128'(0));
    check("rst_mem_valid", 128'(bus.mem_valid_o), 128'(0));
    check("rst_mem_rw", 128'(bus.mem_rw_o), 128'(0));
    check("rst_mem_addr", 128'(bus.mem_addr_o), 128'(0));
    check("rst_mem_wdata", 128'(bus.mem_wdata_o), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(ST_IDLE));

    // scenario 1: fill then hit
    access(32'h40, 0, 0, 0, 0, 0);
    check("s1_rd", 128'(last_rd), 128'(32'h11));
    check("s1_txn", 128'(last_txn), 128'(1));
    access(32'h44, 0, 0, 0, 1, 0);
    check("s1_hit_rd", 128'(last_rd), 128'(32'h22));
    check("s1_hit_txn", 128'(last_txn), 128'(0));
    check("s1_hit_lat", 128'(last_cycles), 128'(2));

    // scenario 2: strobed write hit
    access(32'h48, 1, 32'hDEADBEEF, 4'b0011, 0, 0);
    check("s2_wr_txn", 128'(last_txn), 128'(0));
    access(32'h48, 0, 0, 0, 0, 0);
    check("s2_rd", 128'(last_rd), 128'(32'h0000BEEF));

    // scenario 3: fill set 0 in order, first PLRU victim is way 0
    do_reset();
    for (int i = 0; i < 8; i++) access(32'(i * 32'h40), 0, 0, 0, 0, 0);
    access(32'h200, 0, 0, 0, 0, 0);
    check("s3_no_wb", 128'(last_txn), 128'(1));
    access(32'h000, 0, 0, 0, 0, 0);
    check("s3_miss0", 128'(last_txn), 128'(1));

    // scenario 4: dirty eviction writes back before the fill
    access(32'h000, 1, 32'hCAFEF00D, 4'hF, 0, 0);
    check("s4_wr_hit", 128'(last_txn), 128'(0));
    wb0_seen = 0;
    for (int i = 0; i < 16 && !wb0_seen; i++) access(32'h240 + 32'(i) * 32'h40, 0, 0, 0, 1, 0);
    check("s4_wb_seen", 128'(wb0_seen), 128'(1));
    check("s4_wb_word", 128'(wb0_word), 128'(32'hCAFEF00D));

    // scenario 5: slow memory, CPU lines wiggle meanwhile
    access(32'h10, 0, 0, 0, 5, 1);
    check("s5_high_cycles", 128'(last_high), 128'(6));

    // scenario 6: reset while ALLOCATE is outstanding
    access(32'h40, 0, 0, 0, 0, 0);
    @(negedge clk);
    bus.cpu_valid_i = 1; bus.cpu_addr_i = 32'h20; bus.cpu_rw_i = 0;
    begin
      int n;
      n = 0;
      while (!bus.mem_valid_o && n < 20) begin @(negedge clk); n++; end
      check("s6_alloc_seen", 128'(bus.mem_valid_o), 128'(1));
    end
    bus.cpu_valid_i = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("s6_valid_drop", 128'(bus.mem_valid_o), 128'(0));
    check("s6_state", 128'(dbg_state), 128'(ST_IDLE));
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    check("s6_late_ready", 128'({bus.mem_valid_o, bus.cpu_ready_o}), 128'(0));
    check("s6_state2", 128'(dbg_state), 128'(ST_IDLE));
    model_reset();
    access(32'h40, 0, 0, 0, 0, 0);
    check("s6_remiss", 128'(last_txn), 128'(1));

    // random traffic over 16 tags per set to force evictions
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      ra = ($urandom_range(15, 0) * SETS + $urandom_range(SETS - 1, 0)) * LB
           + $urandom_range(LINE_WORDS - 1, 0) * 4;
      access(ra, 1'($urandom_range(1, 0)), $urandom, 4'($urandom_range(15, 0)),
             $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_ctrl_nway.md
Name: cache_ctrl_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache controller for the RV32I core.
- Sits between the CPU load/store port and the line-granular memory interface.
- Generalises the fixed 8-way/4-set/single-word layout to configurable ways, sets and words per line.
- Adds byte-strobed writes and tree pseudo-LRU replacement.

Parameters:
WAYS, 8, associativity; power of two, >=2
SETS, 4, number of sets; power of two, >=2
LINE_WORDS, 4, 32-bit words per line; power of two, >=1
ADDR_W, 32, byte address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
cpu_valid_i  in  1  CPU request valid
cpu_addr_i  in  ADDR_W  byte address, word aligned
cpu_rw_i  in  1  0=read, 1=write
cpu_wdata_i  in  32  write data
cpu_wstrb_i  in  4  byte enables for writes
cpu_ready_o  out  1  one-cycle result-ready pulse
cpu_rdata_o  out  32  read data, valid with cpu_ready_o
mem_valid_o  out  1  memory request valid
mem_rw_o  out  1  0=line read, 1=line write
mem_addr_o  out  ADDR_W  line-aligned byte address
mem_wdata_o  out  LINE_WORDS*32  writeback line
mem_ready_i  in  1  memory done; read line valid this cycle
mem_rdata_i  in  LINE_WORDS*32  fill line, word 0 in LSBs

Behaviour:
- Clock and reset: clk_i is the only clock. rst_ni is synchronous and active-low.
- Address split:
  - offset = addr[log2(LINE_WORDS)+1:0], word select = addr[log2(LINE_WORDS)+1:2].
  - index = next log2(SETS) bits; tag = remaining MSBs.
- Storage:
  - Per set and way: valid, dirty, tag, line. Per set: WAYS-1 PLRU bits. All in flops.
- Reset (rst_ni=0 at a clock edge):
  - All valid, dirty and PLRU bits cleared; state IDLE.
  - cpu_ready_o=0, cpu_rdata_o=0, mem_valid_o=0, mem_rw_o=0, mem_addr_o=0, mem_wdata_o=0.
  - Applies mid-operation: any in-flight memory transaction is abandoned (mem_valid_o low after that edge). A late mem_ready_i is ignored.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE:
  - If cpu_valid_i, latch addr/rw/wdata/wstrb and go to COMPARE. Otherwise stay.
  - cpu_valid_i is ignored in all other states; the CPU holds it until cpu_ready_o.
- COMPARE, hit (valid and tag match):
  - Read: cpu_rdata_o takes the selected word.
  - Write: merge wdata into the selected word per wstrb; set dirty.
  - Update PLRU toward the hit way. cpu_ready_o=1 for the next cycle only; go to IDLE.
  - Hit latency: request sampled at edge 0, cpu_ready_o high in the cycle after edge 1.
  - A new request may be sampled in the cycle cpu_ready_o is high.
- COMPARE, miss:
  - Victim is the lowest-index invalid way; if none is invalid, the PLRU victim.
  - Victim valid and dirty: go to WRITEBACK. Otherwise go to ALLOCATE.
- WRITEBACK:
  - mem_valid_o=1, mem_rw_o=1, mem_addr_o={victim tag, index, 0}, mem_wdata_o=victim line.
  - These outputs are held stable until mem_ready_i, then go to ALLOCATE.
- ALLOCATE:
  - mem_valid_o=1, mem_rw_o=0, mem_addr_o={req tag, index, 0}.
  - On mem_ready_i: write mem_rdata_i into the victim; set valid=1, dirty=0, tag=req tag; go to COMPARE. The request then hits.
- Memory handshake:
  - mem_ready_i is sampled only while mem_valid_o=1.
  - mem_valid_o drops in the cycle after mem_ready_i. A zero-wait mem_ready_i is legal.
- Tree PLRU:
  - Node bit 0 means the victim lies in the lower half.
  - Each access (hit or fill) sets every node on the way's path to point to the other half.
- Writes never go directly to memory; a line reaches memory only through eviction.

Test Plan:
All scenarios use defaults: index = addr[5:4], tag = addr[31:6].
1. Reset, read 0x40 -> ALLOCATE with mem_addr_o=0x40, rw=0. Return words {0x11,0x22,0x33,0x44} -> cpu_rdata_o=0x11. Then read 0x44 -> hit, no mem_valid_o, cpu_rdata_o=0x22 two cycles after request.
2. After scenario 1, write 0x48 with wdata 0xDEADBEEF, wstrb 4'b0011 -> hit, no memory traffic. Read 0x48 returns 0x0000BEEF.
3. Reads of 0x000, 0x040, ... 0x1C0 fill ways 0..7 of set 0 in order. Read 0x200 -> victim is way 0, no WRITEBACK, mem_addr_o=0x200. A subsequent read of 0x000 misses.
4. Write 0x000 (data 0xCAFEF00D, wstrb 4'hF), then force its eviction -> WRITEBACK precedes ALLOCATE. It carries mem_addr_o=0x000, rw=1, and word 0 of mem_wdata_o = 0xCAFEF00D.
5. mem_ready_i delayed 5 cycles -> mem_valid_o/mem_addr_o/mem_rw_o stay constant for 6 cycles. Toggling cpu_valid_i/cpu_addr_i meanwhile has no effect.
6. rst_ni low for one edge while in ALLOCATE -> mem_valid_o=0 next cycle, state IDLE. A late mem_ready_i is ignored; re-reading the previously cached 0x40 misses.
